// File: rtl/toast_imem_arbiter.sv
// toast_imem_arbiter
// Shares one synchronous single-port instruction memory between the IF-stage
// fetch port and the loader/debug port. One grant per cycle; read data comes
// back one cycle later and is steered to whichever port owned the access.

module toast_imem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_FETCH_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_stall_o,

    input  logic                  ld_req_i,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_wdata_i,
    input  logic                  ld_hold_i,
    output logic                  ld_gnt_o,
    output logic                  ld_rvalid_o,
    output logic [DATA_WIDTH-1:0] ld_rdata_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_FETCH_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_FETCH_BURST);

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LD
    } owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             if_gnt, ld_gnt;

    // State, fetch-burst counter and response owner registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            burst_q <= '0;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            owner_q <= owner_d;
        end
    end

    // Arbitration, next state, burst counting and next response owner
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        owner_d = OWN_NONE;
        if_gnt  = 1'b0;
        ld_gnt  = 1'b0;

        if (!reset_i) begin
            if (state_q == ST_HOLD) begin
                // Loader owns the memory exclusively; the core is held off.
                ld_gnt = ld_req_i;
            end else if (if_req_i && ld_req_i) begin
                // Fetch has priority until it has starved the loader long enough.
                if (burst_q == BURST_MAX) begin
                    ld_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req_i;
                ld_gnt = ld_req_i;
            end

            state_d = ld_hold_i ? ST_HOLD : ST_RUN;

            if (ld_gnt || !ld_req_i) begin
                burst_d = '0;
            end else if (if_gnt && (burst_q != BURST_MAX)) begin
                burst_d = burst_q + CNT_W'(1);
            end

            if (if_gnt) begin
                owner_d = OWN_IF;
            end else if (ld_gnt && !ld_we_i) begin
                owner_d = OWN_LD;
            end
        end
    end

    assign if_gnt_o    = if_gnt;
    assign ld_gnt_o    = ld_gnt;
    assign if_stall_o  = if_req_i & ~if_gnt;

    assign mem_en_o    = if_gnt | ld_gnt;
    assign mem_we_o    = ld_gnt & ld_we_i;
    assign mem_addr_o  = ld_gnt ? ld_addr_i : if_addr_i;
    assign mem_wdata_o = ld_wdata_i;

    // A response still pending when reset arrives is dropped immediately.
    assign if_rvalid_o = (owner_q == OWN_IF) & ~reset_i;
    assign ld_rvalid_o = (owner_q == OWN_LD) & ~reset_i;
    assign if_rdata_o  = mem_rdata_i;
    assign ld_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_toast_imem_arbiter.sv
// tb_toast_imem_arbiter
// Randomized and directed stimulus against a behavioural reference model of
// the instruction memory arbiter, with a small memory macro model attached.

module tb_toast_imem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          if_req_i, if_gnt_o, if_rvalid_o, if_stall_o;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          ld_req_i, ld_we_i, ld_hold_i, ld_gnt_o, ld_rvalid_o;
    logic [AW-1:0] ld_addr_i;
    logic [DW-1:0] ld_wdata_i, ld_rdata_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;

    int testsRun = 0;
    int testsFailed = 0;

    toast_imem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_FETCH_BURST(MAX)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
        .ld_wdata_i(ld_wdata_i), .ld_hold_i(ld_hold_i), .ld_gnt_o(ld_gnt_o),
        .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        return 32'hA5C30000 ^ (i * 32'h01010101);
    endfunction

    // Memory macro: 256 words, synchronous read with one cycle latency
    logic [31:0] macroMem [0:255];
    bit          macroInit;
    always @(posedge clk) begin
        if (!macroInit) begin
            for (int i = 0; i < 256; i++) macroMem[i] <= initWord(i);
            macroInit <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_we_o) macroMem[mem_addr_o[9:2]] <= mem_wdata_o;
            else          mem_rdata_i <= macroMem[mem_addr_o[9:2]];
        end
    end

    // Reference model: loader exclusivity flag, count of fetch wins while the
    // loader has been waiting, the expected pending response and memory image.
    bit          mHold;
    int          mStreak;
    bit          mPendIf, mPendLd;
    logic [31:0] mPendData;
    logic [31:0] refMem [0:255];
    bit          mLastLdGnt;

    logic        lastIfGnt, lastLdGnt, lastLdRv, lastMemWe;
    logic [31:0] lastLdRdata;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check all outputs against the model, advance
    task automatic applyStimulus(input bit rst, input bit ifReq, input logic [31:0] ifAddr,
                                 input bit ldReq, input bit ldWe, input logic [31:0] ldAddr,
                                 input logic [31:0] ldWdata, input bit ldHold);
        bit eIfG, eLdG;
        reset_i = rst; if_req_i = ifReq; if_addr_i = ifAddr;
        ld_req_i = ldReq; ld_we_i = ldWe; ld_addr_i = ldAddr;
        ld_wdata_i = ldWdata; ld_hold_i = ldHold;
        #2;
        eIfG = 1'b0;
        eLdG = 1'b0;
        if (!rst) begin
            if (mHold) begin
                eLdG = ldReq;
            end else if (ifReq && ldReq) begin
                eIfG = (mStreak < MAX);
                eLdG = !eIfG;
            end else begin
                eIfG = ifReq;
                eLdG = ldReq;
            end
        end
        checkOutput("if_gnt", 32'(if_gnt_o), 32'(eIfG));
        checkOutput("ld_gnt", 32'(ld_gnt_o), 32'(eLdG));
        checkOutput("if_stall", 32'(if_stall_o), 32'(ifReq && !eIfG));
        checkOutput("mem_en", 32'(mem_en_o), 32'(eIfG || eLdG));
        checkOutput("mem_we", 32'(mem_we_o), 32'(eLdG && ldWe));
        if (eIfG) checkOutput("mem_addr_if", mem_addr_o, ifAddr);
        if (eLdG) checkOutput("mem_addr_ld", mem_addr_o, ldAddr);
        if (eLdG && ldWe) checkOutput("mem_wdata", mem_wdata_o, ldWdata);
        checkOutput("if_rvalid", 32'(if_rvalid_o), 32'(!rst && mPendIf));
        checkOutput("ld_rvalid", 32'(ld_rvalid_o), 32'(!rst && mPendLd));
        if (!rst && mPendIf) checkOutput("if_rdata", if_rdata_o, mPendData);
        if (!rst && mPendLd) checkOutput("ld_rdata", ld_rdata_o, mPendData);

        lastIfGnt = if_gnt_o; lastLdGnt = ld_gnt_o; lastMemWe = mem_we_o;
        lastLdRv = ld_rvalid_o; lastLdRdata = ld_rdata_o;
        mLastLdGnt = eLdG;

        if (rst) begin
            mHold = 0; mStreak = 0; mPendIf = 0; mPendLd = 0;
        end else begin
            mPendIf = eIfG;
            mPendLd = eLdG && !ldWe;
            if (eIfG) mPendData = refMem[ifAddr[9:2]];
            else if (eLdG && !ldWe) mPendData = refMem[ldAddr[9:2]];
            if (eLdG && ldWe) refMem[ldAddr[9:2]] = ldWdata;
            if (eLdG || !ldReq) mStreak = 0;
            else if (eIfG && mStreak < MAX) mStreak++;
            mHold = ldHold;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          rLdReq, rLdWe, rHold, rIfReq;
        logic [31:0] rLdAddr, rLdWdata;
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
        mHold = 0; mStreak = 0; mPendIf = 0; mPendLd = 0; mPendData = '0;
        reset_i = 1; if_req_i = 0; if_addr_i = 0; ld_req_i = 0; ld_we_i = 0;
        ld_addr_i = 0; ld_wdata_i = 0; ld_hold_i = 0;
        @(posedge clk); #1;

        // Reset state
        applyStimulus(1, 1, 32'h0, 1, 0, 32'h40, 0, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0, 0);

        // Sequential fetch
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'(i * 4), 0, 0, 0, 0, 0);
        idle();

        // Both request: four fetches then one loader grant, repeating
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 32'(32 + i * 4), 1, 0, 32'h80, 0, 0);
            checkOutput("burst_pattern_ld", 32'(lastLdGnt), 32'((i % 5) == 4));
        end
        idle();

        // Loader write then read back
        applyStimulus(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
        checkOutput("ld_write_we", 32'(lastMemWe), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 32'h10, 0, 0);
        idle();
        checkOutput("ld_readback_valid", 32'(lastLdRv), 32'd1);
        checkOutput("ld_readback_data", lastLdRdata, 32'hDEADBEEF);

        // Hold with continuous fetch, then release
        applyStimulus(0, 1, 32'h100, 1, 0, 32'h14, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h104, 1, 0, 32'(32'h18 + i * 4), 0, 1);
        checkOutput("hold_fetch_blocked", 32'(lastIfGnt), 32'd0);
        applyStimulus(0, 1, 32'h104, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h104, 0, 0, 0, 0, 0);
        checkOutput("hold_release_fetch", 32'(lastIfGnt), 32'd1);

        // Reset right after a fetch grant
        applyStimulus(0, 1, 32'h200, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h204, 1, 0, 32'h20, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch alone keeps counter clear; loader then waits four fetches
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 32'(32'h300 + i * 4), 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 32'(32'h340 + i * 4), 1, 0, 32'h24, 0, 0);
            checkOutput("fetch_only_then_ld", 32'(lastLdGnt), 32'(i == 4));
        end
        idle();

        // Randomized traffic honouring the loader hold-until-granted rule
        rLdReq = 0; rLdWe = 0; rLdAddr = 0; rLdWdata = 0; rHold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!(rLdReq && !mLastLdGnt)) begin
                rLdReq   = ($urandom_range(0, 2) != 0);
                rLdWe    = $urandom_range(0, 1) == 1;
                rLdAddr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                rLdWdata = $urandom;
            end
            if ($urandom_range(0, 39) == 0) rHold = !rHold;
            rIfReq = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 99) == 0, rIfReq,
                          {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                          rLdReq, rLdWe, rLdAddr, rLdWdata, rHold);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
